// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter
// ----------------------------------------------------------------------------
// Shares the single base-RAM adapter request port between the instruction
// fetch port (IF) and the data port (MEM). MEM always wins a conflict and the
// losing IF port is held through stall_req_o. After a MEM write the bus can be
// held idle for WR_RECOVERY cycles so the SRAM can recover.
//
// Optional feature: define ARB_PERF_CNT_EN to add the perf_conflict_o and
// perf_recov_o event counters. Without the macro those ports do not exist.
//
// Parameters:
//   DATA_W      data / instruction width
//   ADDR_W      byte address width
//   WR_RECOVERY idle bus cycles forced after each MEM write (0..7)
//   NOP_WORD    word presented on inst_o whenever IF is not served
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   if_ce_i/if_addr_i instruction fetch request and byte address
//   inst_o            fetched instruction (combinational from bus_rdata_i)
//   mem_*_i           data port request: ce, we, addr, byte enables, wdata
//   mem_rdata_o       data port read data (0 unless a MEM read is granted)
//   bus_*_o           request to the adapter (ce, we, addr, sel, wdata)
//   bus_rdata_i       read data from the adapter
//   stall_req_o       freeze PC and IF/ID, bubble ID/EX
//   perf_conflict_o   (ARB_PERF_CNT_EN) cycles with MEM granted while IF asked
//   perf_recov_o      (ARB_PERF_CNT_EN) cycles spent in write recovery
// ============================================================================
module ram_arbiter #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          WR_RECOVERY = 0,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_ce_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] inst_o,

    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,

    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,

    output logic              stall_req_o
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_conflict_o,
    output logic [31:0]       perf_recov_o
`endif
);

    // The counter is 3 bits wide, so WR_RECOVERY is limited to 0..7.
    localparam bit          RECOV_EN   = (WR_RECOVERY > 0);
    localparam logic [2:0]  RECOV_LOAD = RECOV_EN ? 3'(WR_RECOVERY - 1) : 3'd0;
    localparam logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_WORD);

    typedef enum logic [1:0] {
        S_IF    = 2'd0,
        S_MEM   = 2'd1,
        S_RECOV = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;

    // Event strobes used by the optional performance counters.
    logic       mem_grant;
    logic       recov_cycle;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IF;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Grant, next-state and output decode. Grants are combinational from the
    // current state and this cycle's requests so a MEM access never costs an
    // extra cycle. The bus outputs only depend on inputs that are stable for
    // the whole clk period, which the adapter's mid-cycle write strobe needs.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bus_ce_o    = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_sel_o   = 4'h0;
        bus_wdata_o = '0;
        inst_o      = NOP_INST;
        mem_rdata_o = '0;
        stall_req_o = 1'b0;
        mem_grant   = 1'b0;
        recov_cycle = 1'b0;

        case (state_reg)
            S_RECOV: begin
                // Bus held idle; any pending request waits and is not lost.
                recov_cycle = 1'b1;
                stall_req_o = if_ce_i | mem_ce_i;
                if (cnt_reg == 3'd0) begin
                    state_next = S_IF;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end

            // S_MEM is never entered in this build (grants are combinational),
            // so it and the unused encoding decode exactly like S_IF.
            default: begin
                state_next = S_IF;
                if (mem_ce_i) begin
                    mem_grant   = 1'b1;
                    bus_ce_o    = 1'b1;
                    bus_we_o    = mem_we_i;
                    bus_addr_o  = mem_addr_i;
                    bus_sel_o   = mem_sel_i;
                    bus_wdata_o = mem_wdata_i;
                    mem_rdata_o = mem_we_i ? '0 : bus_rdata_i;
                    stall_req_o = if_ce_i;
                    if (mem_we_i && RECOV_EN) begin
                        state_next = S_RECOV;
                        cnt_next   = RECOV_LOAD;
                    end
                end else if (if_ce_i) begin
                    bus_ce_o   = 1'b1;
                    bus_sel_o  = 4'hF;
                    bus_addr_o = if_addr_i;
                    inst_o     = bus_rdata_i;
                end
            end
        endcase

        // While reset is held every output is forced to its quiet value.
        if (!rst) begin
            bus_ce_o    = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_sel_o   = 4'h0;
            bus_wdata_o = '0;
            inst_o      = NOP_INST;
            mem_rdata_o = '0;
            stall_req_o = 1'b0;
            mem_grant   = 1'b0;
            recov_cycle = 1'b0;
        end
    end

`ifdef ARB_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Free-running event counters; they wrap and are only cleared by reset.
    // ------------------------------------------------------------------------
    logic [31:0] perf_conflict_reg;
    logic [31:0] perf_recov_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_conflict_reg <= 32'd0;
            perf_recov_reg    <= 32'd0;
        end else begin
            if (mem_grant && if_ce_i) begin
                perf_conflict_reg <= perf_conflict_reg + 32'd1;
            end
            if (recov_cycle) begin
                perf_recov_reg <= perf_recov_reg + 32'd1;
            end
        end
    end

    assign perf_conflict_o = perf_conflict_reg;
    assign perf_recov_o    = perf_recov_reg;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter
// ----------------------------------------------------------------------------
// Drives three ram_arbiter instances (WR_RECOVERY = 0, 2 and 3) from the same
// request stream and compares every output against a reference model that
// simply tracks "idle cycles still owed after a write" per instance.
// Directed scenarios come first, then randomized traffic with occasional
// resets.
// ============================================================================
module tb_ram_arbiter;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_ce_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        mem_ce_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] bus_rdata_i = '0;

    logic [31:0] inst_w  [NDUT];
    logic [31:0] mrd_w   [NDUT];
    logic        ce_w    [NDUT];
    logic        we_w    [NDUT];
    logic [31:0] addr_w  [NDUT];
    logic [3:0]  sel_w   [NDUT];
    logic [31:0] wd_w    [NDUT];
    logic        st_w    [NDUT];
`ifdef ARB_PERF_CNT_EN
    logic [31:0] pc_w    [NDUT];
    logic [31:0] pr_w    [NDUT];
    logic [31:0] m_conf  [NDUT];
    logic [31:0] m_rec   [NDUT];
`endif

    int tests  = 0;
    int failed = 0;
    int recs [NDUT] = '{0, 2, 3};
    int idle [NDUT] = '{0, 0, 0};

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        ram_arbiter #(
            .DATA_W(32), .ADDR_W(32),
            .WR_RECOVERY(gi == 0 ? 0 : (gi == 1 ? 2 : 3)),
            .NOP_WORD(NOP)
        ) dut (
            .clk(clk), .rst(rst),
            .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .inst_o(inst_w[gi]),
            .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
            .mem_sel_i(mem_sel_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mrd_w[gi]),
            .bus_ce_o(ce_w[gi]), .bus_we_o(we_w[gi]), .bus_addr_o(addr_w[gi]),
            .bus_sel_o(sel_w[gi]), .bus_wdata_o(wd_w[gi]), .bus_rdata_i(bus_rdata_i),
            .stall_req_o(st_w[gi])
`ifdef ARB_PERF_CNT_EN
            , .perf_conflict_o(pc_w[gi]), .perf_recov_o(pr_w[gi])
`endif
        );
    end

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ic, input logic [31:0] ia,
                         input logic mc, input logic mw, input logic [31:0] ma,
                         input logic [3:0] ms, input logic [31:0] mwd,
                         input logic [31:0] rd);
        rst = r; if_ce_i = ic; if_addr_i = ia;
        mem_ce_i = mc; mem_we_i = mw; mem_addr_i = ma;
        mem_sel_i = ms; mem_wdata_i = mwd; bus_rdata_i = rd;
    endtask

    // Check all instances against the model, then advance one clock.
    task automatic cycle(input string tag);
        logic [31:0] e_inst, e_mrd, e_addr, e_wd;
        logic        e_ce, e_we, e_st;
        logic [3:0]  e_sel;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            e_inst = NOP; e_mrd = '0; e_addr = '0; e_wd = '0;
            e_ce = 1'b0; e_we = 1'b0; e_st = 1'b0; e_sel = 4'h0;
            if (rst) begin
                if (idle[d] > 0) begin
                    e_st = if_ce_i | mem_ce_i;
                end else if (mem_ce_i) begin
                    e_ce = 1'b1; e_we = mem_we_i; e_addr = mem_addr_i;
                    e_sel = mem_sel_i; e_wd = mem_wdata_i;
                    e_mrd = mem_we_i ? 32'h0 : bus_rdata_i;
                    e_st = if_ce_i;
                end else if (if_ce_i) begin
                    e_ce = 1'b1; e_sel = 4'hF; e_addr = if_addr_i;
                    e_inst = bus_rdata_i;
                end
            end
            chk({tag, ".ce"},    d, 32'(ce_w[d]),  32'(e_ce));
            chk({tag, ".we"},    d, 32'(we_w[d]),  32'(e_we));
            chk({tag, ".addr"},  d, addr_w[d],     e_addr);
            chk({tag, ".sel"},   d, 32'(sel_w[d]), 32'(e_sel));
            chk({tag, ".wdata"}, d, wd_w[d],       e_wd);
            chk({tag, ".inst"},  d, inst_w[d],     e_inst);
            chk({tag, ".mrd"},   d, mrd_w[d],      e_mrd);
            chk({tag, ".stall"}, d, 32'(st_w[d]),  32'(e_st));
`ifdef ARB_PERF_CNT_EN
            chk({tag, ".pconf"}, d, pc_w[d], m_conf[d]);
            chk({tag, ".precov"}, d, pr_w[d], m_rec[d]);
`endif
        end
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) begin
`ifdef ARB_PERF_CNT_EN
            if (!rst) begin
                m_conf[d] = '0; m_rec[d] = '0;
            end else if (idle[d] > 0) begin
                m_rec[d] = m_rec[d] + 32'd1;
            end else if (mem_ce_i && if_ce_i) begin
                m_conf[d] = m_conf[d] + 32'd1;
            end
`endif
            if (!rst)                               idle[d] = 0;
            else if (idle[d] > 0)                   idle[d] = idle[d] - 1;
            else if (mem_ce_i && mem_we_i && recs[d] > 0) idle[d] = recs[d];
        end
        @(negedge clk);
    endtask

    initial begin
`ifdef ARB_PERF_CNT_EN
        for (int d = 0; d < NDUT; d++) begin m_conf[d] = '0; m_rec[d] = '0; end
`endif
        // Reset with requests present: everything forced quiet.
        drive(0, 1, 32'h8000_0000, 1, 1, 32'h8000_0200, 4'hF, 32'h1111_2222, 32'hDEAD_BEEF);
        cycle("reset0");
        cycle("reset1");
        // 1: IF fetch only.
        drive(1, 1, 32'h8000_0010, 0, 0, 32'h0, 4'h0, 32'h0, 32'h2402_0005);
        cycle("t1_fetch");
        // 2: IF and MEM load conflict, then IF alone.
        drive(1, 1, 32'h8000_0014, 1, 0, 32'h8000_0100, 4'hF, 32'h0, 32'h1234_5678);
        cycle("t2_conflict");
        drive(1, 1, 32'h8000_0014, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0000_0001);
        cycle("t2_after");
        // 3: store with IF requesting, then IF keeps asking.
        drive(1, 1, 32'h8000_0018, 1, 1, 32'h8000_0104, 4'b0011, 32'hAABB_CCDD, 32'h5555_AAAA);
        cycle("t3_store");
        drive(1, 1, 32'h8000_0018, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0BAD_F00D);
        for (int i = 0; i < 4; i++) cycle("t3_recov");
        // 4: three consecutive loads with IF requesting.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h8000_001C, 1, 0, 32'h8000_0200 + 32'(4 * i), 4'hF,
                  32'h0, 32'hC0DE_0000 + 32'(i));
            cycle("t4_load");
        end
        drive(1, 1, 32'h8000_001C, 0, 0, 32'h0, 4'h0, 32'h0, 32'h2222_3333);
        cycle("t4_if");
        // 5: reset during recovery, then immediate IF grant.
        drive(1, 1, 32'h8000_0020, 1, 1, 32'h8000_0300, 4'hF, 32'h7777_8888, 32'h0);
        cycle("t5_store");
        drive(1, 1, 32'h8000_0020, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        cycle("t5_idle");
        drive(0, 1, 32'h8000_0020, 1, 0, 32'h8000_0304, 4'hF, 32'h0, 32'h4444_0000);
        cycle("t5_rst");
        drive(1, 1, 32'h8000_0024, 0, 0, 32'h0, 4'h0, 32'h0, 32'h4444_0001);
        cycle("t5_release");
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) != 0), 1'($urandom), $urandom,
                  1'($urandom), 1'($urandom), $urandom, 4'($urandom),
                  $urandom, $urandom);
            cycle("rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sits directly upstream of the base-RAM adapter. It multiplexes the instruction-fetch port (IF) and the data port (MEM) onto the adapter's single request port (ce/we/addr/sel/data), and returns read data to the winner.
- MEM always wins a conflict. IF is stalled through stall_req_o to the pipeline controller.
- An optional post-write recovery counter holds the bus idle after SRAM writes.

Parameters:
- DATA_W, 32, data/instruction width.
- ADDR_W, 32, byte address width.
- WR_RECOVERY, 0, idle bus cycles forced after every MEM write (0..7).
- NOP_WORD, 32'h0000_0000, word driven on inst_o when IF is not served.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets on rising clk).
- if_ce_i  in  1  IF fetch request.
- if_addr_i  in  ADDR_W  fetch byte address.
- inst_o  out  DATA_W  fetched instruction (combinational from bus_rdata_i when IF is granted).
- mem_ce_i  in  1  MEM access request.
- mem_we_i  in  1  MEM write (1) / read (0).
- mem_addr_i  in  ADDR_W  MEM byte address.
- mem_sel_i  in  4  MEM byte enables.
- mem_wdata_i  in  DATA_W  MEM write data.
- mem_rdata_o  out  DATA_W  MEM read data.
- bus_ce_o  out  1  to adapter ce_i.
- bus_we_o  out  1  to adapter we_i.
- bus_addr_o  out  ADDR_W  to adapter addr_i.
- bus_sel_o  out  4  to adapter sel_i.
- bus_wdata_o  out  DATA_W  to adapter data_i.
- bus_rdata_i  in  DATA_W  from adapter data_o.
- stall_req_o  out  1  freeze PC and IF/ID, bubble ID/EX.

Behaviour:
- States:
  - S_IF: IF owns the bus. This is the reset state.
  - S_MEM: MEM owns the bus for exactly one cycle.
  - S_RECOV: idle bus, counter running.
- Grant logic is combinational from the state plus this cycle's requests. The state register updates on clk.
- S_IF:
  - mem_ce_i=1: MEM granted this cycle. Bus mirrors the mem_* inputs; mem_rdata_o=bus_rdata_i when mem_we_i=0. If if_ce_i=1, stall_req_o=1 and inst_o=NOP_WORD. Next state = S_RECOV if the access is a write and WR_RECOVERY>0; otherwise S_IF.
  - mem_ce_i=0, if_ce_i=1: IF granted. bus_ce_o=1, bus_we_o=0, bus_sel_o=4'hF, bus_addr_o=if_addr_i, inst_o=bus_rdata_i, stall_req_o=0.
  - Neither request: bus_ce_o=0. All bus outputs 0.
- S_MEM: reserved for registered-grant builds. Behaves exactly as S_IF with mem_ce_i=1, then returns to S_IF. It is unreachable in the default build and must decode as S_IF.
- S_RECOV:
  - Counter loads WR_RECOVERY-1 on entry and decrements each cycle.
  - bus_ce_o=0. stall_req_o=1 if either request is pending. inst_o=NOP_WORD, mem_rdata_o=0.
  - Exit to S_IF when the counter is 0 at a clock edge.
  - A new MEM request during S_RECOV waits (stalled); it is not dropped.
- Counter is 3 bits wide. WR_RECOVERY=0 never enters S_RECOV.
- Back-to-back MEM accesses: each is granted in its own cycle. IF stays stalled for the whole run; no starvation limit.
- mem_rdata_o=0 whenever MEM is not granted or on a write cycle.
- Reset (rst==0 at a clock edge, including mid-recovery): state=S_IF, counter=0.
  - While rst==0, all outputs are forced low: bus_*=0, stall_req_o=0, mem_rdata_o=0, inst_o=NOP_WORD.
  - First cycle after release: normal S_IF arbitration.
- Inputs are not registered. The adapter's half-cycle write strobe relies on bus_* being stable for the full clk period.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_conflict_o[31:0] and perf_recov_o[31:0].
  - perf_conflict_o counts cycles with MEM granted while if_ce_i=1.
  - perf_recov_o counts S_RECOV cycles.
  - Both reset to 0 on rst==0, wrap at 2^32, and are never cleared otherwise.
- Undefined: ports and logic absent. Behaviour is otherwise identical.

Test Plan:
1. IF fetch only, if_addr_i=0x80000010, bus_rdata_i=0x24020005 -> bus_addr_o=0x80000010, bus_sel_o=F, inst_o=0x24020005, stall_req_o=0.
2. IF fetch plus MEM load (mem_addr_i=0x80000100) in the same cycle, bus_rdata_i=0x12345678 -> bus_addr_o=0x80000100, mem_rdata_o=0x12345678, inst_o=0, stall_req_o=1. Next cycle with mem_ce_i=0 -> IF granted, stall_req_o=0.
3. WR_RECOVERY=2: MEM store sel=4'b0011 data=0xAABBCCDD, IF requesting -> cycle0 bus_we_o=1, sel=3; cycles1-2 bus_ce_o=0, stall_req_o=1; cycle3 IF granted.
4. Three consecutive MEM loads with IF requesting -> stall_req_o=1 for 3 cycles, bus address follows each mem_addr_i, IF served on cycle 4.
5. Reset asserted during S_RECOV (WR_RECOVERY=3, after 1 idle cycle) -> next edge all bus outputs 0, stall_req_o=0. After release, an IF request is granted immediately.
6. ARB_PERF_CNT_EN defined: run scenario 2 then scenario 3 -> perf_conflict_o=2, perf_recov_o=2.
